// File: rtl/vga_pkg.sv
// Shared definitions for the VGA drawing blocks: FSM encoding, screen
// defaults and the palette used by the piano-tiles top.
package vga_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAW   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  localparam int SCREEN_W_DEFAULT = 640;
  localparam int SCREEN_H_DEFAULT = 480;

  localparam logic [23:0] BLACK       = 24'h000000;
  localparam logic [23:0] WHITE       = 24'hFFFFFF;
  localparam logic [23:0] TILE_RED    = 24'hFF0000;
  localparam logic [23:0] TILE_GREEN  = 24'h00FF00;
  localparam logic [23:0] TILE_BLUE   = 24'h0000FF;
  localparam logic [23:0] TILE_YELLOW = 24'hFFFF00;

endpackage

// File: rtl/rect_raster_counter.sv
// Row-major column/row counter pair for one rectangle scan. Wraps on the
// clipped extent, flags the final pixel and the unclipped border.
module rect_raster_counter
  import vga_pkg::*;
#(
  parameter int X_W = 10,
  parameter int Y_W = 9
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           advance,
  input  logic [X_W:0]   ew,
  input  logic [Y_W:0]   eh,
  input  logic [X_W-1:0] w,
  input  logic [Y_W-1:0] h,
  output logic [X_W-1:0] cx,
  output logic [Y_W-1:0] cy,
  output logic           last_pixel,
  output logic           border
);

  localparam logic [X_W-1:0] CX_ONE = {{(X_W-1){1'b0}}, 1'b1};
  localparam logic [Y_W-1:0] CY_ONE = {{(Y_W-1){1'b0}}, 1'b1};
  localparam logic [X_W:0]   EW_ONE = {{X_W{1'b0}}, 1'b1};
  localparam logic [Y_W:0]   EH_ONE = {{Y_W{1'b0}}, 1'b1};

  logic [X_W-1:0] cx_r;
  logic [Y_W-1:0] cy_r;
  logic           col_last_s;
  logic           row_last_s;
  logic           border_s;

  // End-of-row / end-of-scan detection and border test against unclipped size
  always_comb begin
    col_last_s = ({1'b0, cx_r} == (ew - EW_ONE));
    row_last_s = ({1'b0, cy_r} == (eh - EH_ONE));
    border_s   = (cx_r == {X_W{1'b0}}) || (cx_r == (w - CX_ONE)) ||
                 (cy_r == {Y_W{1'b0}}) || (cy_r == (h - CY_ONE));
  end

  // Counter pair: cleared on start, stepped row-major while advancing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cx_r <= {X_W{1'b0}};
      cy_r <= {Y_W{1'b0}};
    end else if (start) begin
      cx_r <= {X_W{1'b0}};
      cy_r <= {Y_W{1'b0}};
    end else if (advance) begin
      if (col_last_s) begin
        cx_r <= {X_W{1'b0}};
        cy_r <= cy_r + CY_ONE;
      end else begin
        cx_r <= cx_r + CX_ONE;
      end
    end
  end

  assign cx         = cx_r;
  assign cy         = cy_r;
  assign last_pixel = col_last_s && row_last_s;
  assign border     = border_s;

endmodule

// File: rtl/vga_rect_plotter.sv
// Rectangle drawing engine: accepts one clipped fill/outline request and
// emits one registered pixel write per clock on the VGA pixel interface.
module vga_rect_plotter
  import vga_pkg::*;
#(
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int COLOR_W  = 24,
  parameter int SCREEN_W = SCREEN_W_DEFAULT,
  parameter int SCREEN_H = SCREEN_H_DEFAULT
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [X_W-1:0]     req_x,
  input  logic [Y_W-1:0]     req_y,
  input  logic [X_W-1:0]     req_w,
  input  logic [Y_W-1:0]     req_h,
  input  logic [COLOR_W-1:0] req_color,
  input  logic               req_mode,
  output logic [X_W-1:0]     VGA_X,
  output logic [Y_W-1:0]     VGA_Y,
  output logic [COLOR_W-1:0] VGA_COLOR,
  output logic               plot,
  output logic               busy,
  output logic               done
);

  localparam logic [X_W:0] SW_L = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SH_L = (Y_W+1)'(SCREEN_H);

  state_t             state_r;
  state_t             next_state_s;
  logic               accept_s;
  logic               advance_s;

  logic [X_W-1:0]     x_r;
  logic [Y_W-1:0]     y_r;
  logic [X_W-1:0]     w_r;
  logic [Y_W-1:0]     h_r;
  logic [COLOR_W-1:0] color_r;
  logic               mode_r;
  logic [X_W:0]       ew_r;
  logic [Y_W:0]       eh_r;

  logic [X_W:0]       rem_x_s;
  logic [Y_W:0]       rem_y_s;
  logic [X_W:0]       ew_s;
  logic [Y_W:0]       eh_s;

  logic [X_W-1:0]     cx_s;
  logic [Y_W-1:0]     cy_s;
  logic               last_pixel_s;
  logic               border_s;

  // Visible extent of the incoming request, one bit wider than the inputs
  always_comb begin
    rem_x_s = SW_L - {1'b0, req_x};
    rem_y_s = SH_L - {1'b0, req_y};
    if ({1'b0, req_x} >= SW_L) begin
      ew_s = {(X_W+1){1'b0}};
    end else if ({1'b0, req_w} < rem_x_s) begin
      ew_s = {1'b0, req_w};
    end else begin
      ew_s = rem_x_s;
    end
    if ({1'b0, req_y} >= SH_L) begin
      eh_s = {(Y_W+1){1'b0}};
    end else if ({1'b0, req_h} < rem_y_s) begin
      eh_s = {1'b0, req_h};
    end else begin
      eh_s = rem_y_s;
    end
  end

  // Next-state logic; an empty visible area skips straight to FINISH
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          accept_s = 1'b1;
          if ((ew_s == {(X_W+1){1'b0}}) || (eh_s == {(Y_W+1){1'b0}})) begin
            next_state_s = ST_FINISH;
          end else begin
            next_state_s = ST_DRAW;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_DRAW: begin
        if (last_pixel_s) begin
          next_state_s = ST_FINISH;
        end else begin
          next_state_s = ST_DRAW;
        end
      end
      ST_FINISH: next_state_s = ST_IDLE;
      default:   next_state_s = ST_IDLE;
    endcase
  end

  assign advance_s = (state_r == ST_DRAW);

  // State register
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Request capture; inputs are only looked at on the accept edge
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      x_r     <= {X_W{1'b0}};
      y_r     <= {Y_W{1'b0}};
      w_r     <= {X_W{1'b0}};
      h_r     <= {Y_W{1'b0}};
      color_r <= {COLOR_W{1'b0}};
      mode_r  <= 1'b0;
      ew_r    <= {(X_W+1){1'b0}};
      eh_r    <= {(Y_W+1){1'b0}};
    end else if (accept_s) begin
      x_r     <= req_x;
      y_r     <= req_y;
      w_r     <= req_w;
      h_r     <= req_h;
      color_r <= req_color;
      mode_r  <= req_mode;
      ew_r    <= ew_s;
      eh_r    <= eh_s;
    end
  end

  rect_raster_counter #(
    .X_W (X_W),
    .Y_W (Y_W)
  ) u_counter (
    .clk        (CLOCK_50),
    .rst        (reset),
    .start      (accept_s),
    .advance    (advance_s),
    .ew         (ew_r),
    .eh         (eh_r),
    .w          (w_r),
    .h          (h_r),
    .cx         (cx_s),
    .cy         (cy_s),
    .last_pixel (last_pixel_s),
    .border     (border_s)
  );

  // Registered outputs; ready drops on the accept edge and returns only after FINISH
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      plot      <= 1'b0;
      VGA_X     <= {X_W{1'b0}};
      VGA_Y     <= {Y_W{1'b0}};
      VGA_COLOR <= {COLOR_W{1'b0}};
    end else begin
      req_ready <= (state_r == ST_IDLE) && (next_state_s == ST_IDLE);
      busy      <= (state_r == ST_DRAW);
      done      <= (state_r == ST_FINISH);
      plot      <= (state_r == ST_DRAW) && (!mode_r || border_s);
      if (state_r == ST_DRAW) begin
        VGA_X     <= x_r + cx_s;
        VGA_Y     <= y_r + cy_s;
        VGA_COLOR <= color_r;
      end
    end
  end

endmodule

// File: tb/tb_vga_rect_plotter.sv
// Self-checking bench for vga_rect_plotter: directed corner cases plus
// randomized rectangles checked against a plain-arithmetic raster model.
module tb_vga_rect_plotter;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_x;
  logic [8:0]  req_y;
  logic [9:0]  req_w;
  logic [8:0]  req_h;
  logic [23:0] req_color;
  logic        req_mode;
  logic [9:0]  vga_x;
  logic [8:0]  vga_y;
  logic [23:0] vga_color;
  logic        plot;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  vga_rect_plotter dut (
    .CLOCK_50  (clk),
    .reset     (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_w     (req_w),
    .req_h     (req_h),
    .req_color (req_color),
    .req_mode  (req_mode),
    .VGA_X     (vga_x),
    .VGA_Y     (vga_y),
    .VGA_COLOR (vga_color),
    .plot      (plot),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Draws one rectangle and checks every scan cycle against the reference raster.
  task automatic run_rect(input int x, input int y, input int w, input int h,
                          input logic [23:0] col, input bit mode,
                          input bit hold, input int nx, input int ny, input int nw,
                          input int nh, input logic [23:0] ncol, input bit nmode,
                          output int plots);
    int ew;
    int eh;
    int waited;
    bit on;
    plots  = 0;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    chk("ready_before_req", 32'(req_ready), 32'd1);
    req_x = 10'(x); req_y = 9'(y); req_w = 10'(w); req_h = 9'(h);
    req_color = col; req_mode = mode; req_valid = 1'b1;
    tick();
    if (hold) begin
      req_x = 10'(nx); req_y = 9'(ny); req_w = 10'(nw); req_h = 9'(nh);
      req_color = ncol; req_mode = nmode;
    end else begin
      req_valid = 1'b0;
      req_x = 10'($urandom); req_y = 9'($urandom); req_w = 10'($urandom);
      req_h = 9'($urandom); req_color = 24'($urandom); req_mode = 1'($urandom);
    end
    chk("ready_low_after_accept", 32'(req_ready), 32'd0);
    ew = (x >= 640) ? 0 : ((w < 640 - x) ? w : 640 - x);
    eh = (y >= 480) ? 0 : ((h < 480 - y) ? h : 480 - y);
    for (int r = 0; r < eh; r++) begin
      for (int c = 0; c < ew; c++) begin
        tick();
        on = (mode == 1'b0) || (c == 0) || (c == w - 1) || (r == 0) || (r == h - 1);
        chk("plot", 32'(plot), 32'(on));
        chk("busy_draw", 32'(busy), 32'd1);
        chk("done_draw", 32'(done), 32'd0);
        if (on) begin
          plots++;
          chk("vga_x", 32'(vga_x), 32'(x + c));
          chk("vga_y", 32'(vga_y), 32'(y + r));
          chk("vga_color", 32'(vga_color), 32'(col));
          chk("x_on_screen", 32'(vga_x < 10'd640), 32'd1);
        end
      end
    end
    tick();
    chk("done_pulse", 32'(done), 32'd1);
    chk("plot_finish", 32'(plot), 32'd0);
    chk("busy_finish", 32'(busy), 32'd0);
    chk("ready_finish", 32'(req_ready), 32'd0);
    tick();
    chk("done_clear", 32'(done), 32'd0);
    chk("ready_return", 32'(req_ready), 32'd1);
  endtask

  initial begin
    int n;
    int rx, ry, rw, rh;
    rst = 1'b1;
    req_valid = 1'b0;
    req_x = 10'd0; req_y = 9'd0; req_w = 10'd0; req_h = 9'd0;
    req_color = 24'd0; req_mode = 1'b0;
    #12;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_plot", 32'(plot), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_vga_x", 32'(vga_x), 32'd0);
    chk("rst_vga_y", 32'(vga_y), 32'd0);
    chk("rst_vga_color", 32'(vga_color), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_rect(10, 20, 3, 2, 24'hFF0000, 1'b0, 1'b0, 0, 0, 0, 0, 24'd0, 1'b0, n);
    chk("plots_fill", 32'(n), 32'd6);
    run_rect(0, 0, 4, 3, 24'h00FF00, 1'b1, 1'b0, 0, 0, 0, 0, 24'd0, 1'b0, n);
    chk("plots_outline", 32'(n), 32'd10);
    run_rect(638, 478, 5, 5, 24'h0000FF, 1'b0, 1'b0, 0, 0, 0, 0, 24'd0, 1'b0, n);
    chk("plots_clip", 32'(n), 32'd4);
    run_rect(50, 50, 0, 3, 24'hFFFFFF, 1'b0, 1'b0, 0, 0, 0, 0, 24'd0, 1'b0, n);
    chk("plots_zero_w", 32'(n), 32'd0);
    run_rect(700, 10, 5, 5, 24'hFFFFFF, 1'b0, 1'b0, 0, 0, 0, 0, 24'd0, 1'b0, n);
    chk("plots_offscreen", 32'(n), 32'd0);

    // Second request held valid throughout the first draw
    run_rect(200, 100, 2, 2, 24'h123456, 1'b0, 1'b1, 300, 150, 3, 1, 24'hABCDEF, 1'b0, n);
    chk("plots_busy_first", 32'(n), 32'd4);
    run_rect(300, 150, 3, 1, 24'hABCDEF, 1'b0, 1'b0, 0, 0, 0, 0, 24'd0, 1'b0, n);
    chk("plots_busy_second", 32'(n), 32'd3);

    // Asynchronous reset while the third pixel of a 4x4 fill is on the outputs
    req_x = 10'd100; req_y = 9'd50; req_w = 10'd4; req_h = 9'd4;
    req_color = 24'h00FFFF; req_mode = 1'b0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick(); tick(); tick();
    chk("abort_pixel3_x", 32'(vga_x), 32'd102);
    chk("abort_pixel3_plot", 32'(plot), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_plot", 32'(plot), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    tick(); tick();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_no_plot", 32'(plot), 32'd0);
    end
    run_rect(5, 5, 2, 3, 24'hFF00FF, 1'b1, 1'b0, 0, 0, 0, 0, 24'd0, 1'b0, n);
    chk("plots_after_abort", 32'(n), 32'd6);

    // Random rectangles, biased toward the screen edges to exercise clipping
    for (int k = 0; k < 25; k++) begin
      rx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(630, 700)) : int'($urandom_range(0, 639));
      ry = ($urandom_range(0, 3) == 0) ? int'($urandom_range(470, 511)) : int'($urandom_range(0, 479));
      rw = int'($urandom_range(0, 7));
      rh = int'($urandom_range(0, 7));
      run_rect(rx, ry, rw, rh, 24'($urandom), 1'($urandom), 1'b0, 0, 0, 0, 0, 24'd0, 1'b0, n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
